alu_result_serializer: RTL

Downstream stage of the 32-bit ALU. Captures each 64-bit ALU result with its carry/zero flags and opcode tag into a small FIFO, then streams it out over a 32-bit valid/ready bus as one or two beats. Results whose upper word is zero go out as a single beat. The block decouples the combinational ALU from a narrower, back-pressured consumer such as a register-file writeback port or a debug/UART link.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_result_serializer_if.sv | 48 ++++
 rtl/alu_result_fifo.sv | 75 +++++++
 rtl/alu_result_serializer.sv | 114 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 32-bit ALU and its result serializer:
//   - result / opcode widths
//   - alu_result_t : one buffered result {tag, C, Z, res}
//   - ser_state_t  : beat state of the output serializer
//   - opcode constants produced by the ALU
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_OPC_W = 4;
   localparam int ALU_RES_W = 64;

   typedef struct packed {
      logic [ALU_OPC_W-1:0] tag;
      logic                 c;
      logic                 z;
      logic [ALU_RES_W-1:0] res;
   } alu_result_t;

   typedef enum logic {
      BEAT_LO = 1'b0,
      BEAT_HI = 1'b1
   } ser_state_t;

   localparam logic [ALU_OPC_W-1:0] OPC_ADD  = 4'h0;
   localparam logic [ALU_OPC_W-1:0] OPC_SUB  = 4'h1;
   localparam logic [ALU_OPC_W-1:0] OPC_AND  = 4'h2;
   localparam logic [ALU_OPC_W-1:0] OPC_MUL  = 4'h3;
   localparam logic [ALU_OPC_W-1:0] OPC_OR   = 4'h4;
   localparam logic [ALU_OPC_W-1:0] OPC_XOR  = 4'h5;
   localparam logic [ALU_OPC_W-1:0] OPC_SHL  = 4'h6;
   localparam logic [ALU_OPC_W-1:0] OPC_SHR  = 4'h7;

endpackage

// File: rtl/alu_result_serializer_if.sv
// -----------------------------------------------------------------------------
// alu_result_serializer_if
// Bundles the producer-side and consumer-side buses of alu_result_serializer.
//   slave  : view of the serializer (takes results, emits beats)
//   master : view of the environment (ALU producer + beat consumer)
// Handshake rule (both buses): a transfer happens on a rising clock edge where
// valid && ready. The sender keeps valid and payload stable until that edge;
// ready may change freely and never depends combinationally on valid.
// -----------------------------------------------------------------------------
interface alu_result_serializer_if #(
   parameter int DEPTH = 4,
   parameter int OUT_W = 32
);
   import alu_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   // producer side
   logic                 in_valid;
   logic                 in_ready;
   logic [ALU_RES_W-1:0] Result;
   logic                 flagC;
   logic                 flagZ;
   logic [ALU_OPC_W-1:0] Opcode;
   // consumer side
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_W-1:0]     out_data;
   logic                 out_last;
   logic                 out_hi;
   logic [1:0]           out_flags;
   logic [ALU_OPC_W-1:0] out_tag;
   // status
   logic [CNT_W-1:0]     count;

   modport slave (
      input  in_valid, Result, flagC, flagZ, Opcode, out_ready,
      output in_ready, out_valid, out_data, out_last, out_hi, out_flags,
             out_tag, count
   );

   modport master (
      output in_valid, Result, flagC, flagZ, Opcode, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_hi, out_flags,
             out_tag, count
   );

endinterface

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
// Circular buffer of alu_result_t entries with read/write pointers and a
// registered occupancy counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : store entry_i (caller guarantees !full_o)
//   entry_i    : entry to store
//   pop_i      : drop head entry (caller guarantees !empty_o)
//   head_o     : entry at the read pointer
//   count_o    : occupied entries
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// -----------------------------------------------------------------------------
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  alu_result_t                entry_i,
   input  logic                       pop_i,
   output alu_result_t                head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   alu_result_t      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= entry_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_result_serializer.sv
// -----------------------------------------------------------------------------
// alu_result_serializer
// Buffers 64-bit ALU results (with C/Z flags and opcode tag) and streams each
// one out as one 32-bit beat (upper word zero) or two beats (low, then high).
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : alu_result_serializer_if.slave
//                 in_valid/in_ready/Result/flagC/flagZ/Opcode  producer bus
//                 out_valid/out_ready/out_data/out_last/out_hi/
//                 out_flags/out_tag                             consumer bus
//                 count                                         occupancy
//   dbg_state_o : current beat state (BEAT_LO / BEAT_HI)
// -----------------------------------------------------------------------------
module alu_result_serializer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int OUT_W = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   alu_result_serializer_if.slave      bus,
   output ser_state_t                  dbg_state_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   ser_state_t        state_q, state_d;
   alu_result_t       head;
   alu_result_t       entry_in;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              out_last;
   logic              out_hi;
   logic [1:0]        out_flags;
   logic [ALU_OPC_W-1:0] out_tag;

   assign entry_in = '{tag: bus.Opcode, c: bus.flagC, z: bus.flagZ, res: bus.Result};

   // in_ready is not-full only; a pop in the same cycle does not make room.
   assign push      = bus.in_valid && !fifo_full;
   assign out_valid = !fifo_empty;

   alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .entry_i (entry_in),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BEAT_LO;
      else        state_q <= state_d;
   end

   // Payload is forced to zero whenever nothing is buffered, so stale storage
   // never leaks onto the bus.
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      out_hi    = 1'b0;
      out_flags = 2'b00;
      out_tag   = '0;
      if (out_valid) begin
         out_flags = {head.c, head.z};
         out_tag   = head.tag;
         case (state_q)
            BEAT_LO: begin
               out_data = head.res[OUT_W-1:0];
               out_last = (head.res[2*OUT_W-1:OUT_W] == '0);
               if (bus.out_ready) begin
                  if (out_last) pop     = 1'b1;
                  else          state_d = BEAT_HI;
               end
            end
            BEAT_HI: begin
               out_data = head.res[2*OUT_W-1:OUT_W];
               out_last = 1'b1;
               out_hi   = 1'b1;
               if (bus.out_ready) begin
                  pop     = 1'b1;
                  state_d = BEAT_LO;
               end
            end
            default: state_d = BEAT_LO;
         endcase
      end
   end

   assign bus.in_ready  = !fifo_full;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_last  = out_last;
   assign bus.out_hi    = out_hi;
   assign bus.out_flags = out_flags;
   assign bus.out_tag   = out_tag;
   assign bus.count     = fifo_count;
   assign dbg_state_o   = state_q;

endmodule
